tl_ul_port_buffer: RTL and testbench

TL_UL_PORT_BUFFER -- requirements
Module: tl_ul_port_buffer

---
 rtl/tl_ul_port_buffer_pkg.sv | 49 ++++
 rtl/tl_ul_fifo2.sv | 89 ++++++++
 rtl/tl_ul_port_buffer.sv | 186 ++++++++++++++++++
 tb/tb_tl_ul_port_buffer.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_ul_port_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tl_ul_port_buffer_pkg
// Description : Shared types and constants for the TL-UL port buffer.
//               Holds the A/D beat payload structs (all header fields except
//               source, whose width is set per instance), the TileLink
//               opcode constants and the per-channel FIFO depth.
// Revision    : 1.0 - initial release
// ============================================================================
package tl_ul_port_buffer_pkg;

    // Entries per channel FIFO.
    localparam int c_fifo_depth = 2;

    // A-channel opcodes.
    localparam logic [2:0] c_a_put_full_data    = 3'd0;
    localparam logic [2:0] c_a_put_partial_data = 3'd1;
    localparam logic [2:0] c_a_arithmetic_data  = 3'd2;
    localparam logic [2:0] c_a_logical_data     = 3'd3;
    localparam logic [2:0] c_a_get              = 3'd4;
    localparam logic [2:0] c_a_intent           = 3'd5;

    // D-channel opcodes.
    localparam logic [2:0] c_d_access_ack       = 3'd0;
    localparam logic [2:0] c_d_access_ack_data  = 3'd1;
    localparam logic [2:0] c_d_hint_ack         = 3'd2;

    // A beat payload without the source field.
    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [2:0]  size;
        logic [31:0] address;
        logic [7:0]  mask;
        logic        corrupt;
    } a_beat_t;

    // D beat payload without the source field.
    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [2:0]  size;
        logic        denied;
        logic        corrupt;
        logic [63:0] data;
    } d_beat_t;

endpackage : tl_ul_port_buffer_pkg
`default_nettype wire

// File: rtl/tl_ul_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : tl_ul_fifo2
// Description : Small registered FIFO used for both TL-UL channels.
//               Ports:
//                 clk, rst                 - clock, synchronous active-high reset
//                 i_in_valid/o_in_ready    - enqueue handshake
//                 i_in_data   [W]          - enqueue payload
//                 o_out_valid/i_out_ready  - dequeue handshake
//                 o_out_data  [W]          - head payload (register output)
//               o_in_ready is !full from registered state only, so there is
//               no path from i_out_ready to o_in_ready; a full FIFO refuses
//               data even in a cycle where it dequeues.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_ul_fifo2
    import tl_ul_port_buffer_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = c_fifo_depth
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [W-1:0] i_in_data,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [W-1:0] o_out_data
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic [W-1:0]       r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_rdy_en;   // holds ready low while in reset

    logic w_full;
    logic w_enq;
    logic w_deq;

    function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] p);
        if (p == c_ptr_w'(DEPTH - 1)) begin
            return '0;
        end
        return p + c_ptr_w'(1);
    endfunction

    assign w_full      = (r_count == c_cnt_w'(DEPTH));
    assign o_in_ready  = r_rdy_en && !w_full;
    assign o_out_valid = (r_count != '0);
    assign o_out_data  = r_mem[r_rd_ptr];
    assign w_enq       = i_in_valid && o_in_ready;
    assign w_deq       = o_out_valid && i_out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_enq) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_deq) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage carries no reset; validity comes from r_count.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= i_in_data;
        end
    end

endmodule : tl_ul_fifo2
`default_nettype wire

// File: rtl/tl_ul_port_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tl_ul_port_buffer
// Description : TL-UL port buffer. Registers the A channel (upstream ->
//               downstream) and the D channel (downstream -> upstream) in
//               two-entry FIFOs and limits outstanding requests.
//               Ports:
//                 clock, reset            - clock, synchronous active-high reset
//                 a_in_*  / a_out_*       - A channel in / out (out is monitored)
//                 d_in_*  / d_out_*       - D channel in / out
//                 inflight [4]            - outstanding request count
//                 err_underflow           - pulse: D accepted with nothing outstanding
// Revision    : 1.0 - initial release
// ============================================================================
module tl_ul_port_buffer
    import tl_ul_port_buffer_pkg::*;
#(
    parameter int SRC_W        = 2,
    parameter int MAX_INFLIGHT = 4,
    parameter int DEPTH        = c_fifo_depth
) (
    input  logic             clock,
    input  logic             reset,
    // A channel, upstream side
    input  logic             a_in_valid,
    output logic             a_in_ready,
    input  logic [2:0]       a_in_opcode,
    input  logic [2:0]       a_in_param,
    input  logic [2:0]       a_in_size,
    input  logic [SRC_W-1:0] a_in_source,
    input  logic [31:0]      a_in_address,
    input  logic [7:0]       a_in_mask,
    input  logic             a_in_corrupt,
    // A channel, downstream side
    output logic             a_out_valid,
    input  logic             a_out_ready,
    output logic [2:0]       a_out_opcode,
    output logic [2:0]       a_out_param,
    output logic [2:0]       a_out_size,
    output logic [SRC_W-1:0] a_out_source,
    output logic [31:0]      a_out_address,
    output logic [7:0]       a_out_mask,
    output logic             a_out_corrupt,
    // D channel, downstream side
    input  logic             d_in_valid,
    output logic             d_in_ready,
    input  logic [2:0]       d_in_opcode,
    input  logic [2:0]       d_in_param,
    input  logic [2:0]       d_in_size,
    input  logic [SRC_W-1:0] d_in_source,
    input  logic             d_in_denied,
    input  logic             d_in_corrupt,
    input  logic [63:0]      d_in_data,
    // D channel, upstream side
    output logic             d_out_valid,
    input  logic             d_out_ready,
    output logic [2:0]       d_out_opcode,
    output logic [2:0]       d_out_param,
    output logic [2:0]       d_out_size,
    output logic [SRC_W-1:0] d_out_source,
    output logic             d_out_denied,
    output logic             d_out_corrupt,
    output logic [63:0]      d_out_data,
    // Status
    output logic [3:0]       inflight,
    output logic             err_underflow
);

    // Source is appended above the struct since its width is per instance.
    localparam int c_a_w = $bits(a_beat_t) + SRC_W;
    localparam int c_d_w = $bits(d_beat_t) + SRC_W;

    a_beat_t          w_a_in_beat;
    a_beat_t          w_a_out_beat;
    d_beat_t          w_d_in_beat;
    d_beat_t          w_d_out_beat;
    logic [SRC_W-1:0] w_a_out_source;
    logic [SRC_W-1:0] w_d_out_source;
    logic [c_a_w-1:0] w_a_out_data;
    logic [c_d_w-1:0] w_d_out_data;

    logic       w_a_fifo_valid;
    logic       w_a_allow;
    logic       w_a_fire;
    logic       w_d_fire;
    logic [3:0] r_inflight;
    logic       r_err_underflow;

    always_comb begin
        w_a_in_beat         = '0;
        w_a_in_beat.opcode  = a_in_opcode;
        w_a_in_beat.param   = a_in_param;
        w_a_in_beat.size    = a_in_size;
        w_a_in_beat.address = a_in_address;
        w_a_in_beat.mask    = a_in_mask;
        w_a_in_beat.corrupt = a_in_corrupt;

        w_d_in_beat         = '0;
        w_d_in_beat.opcode  = d_in_opcode;
        w_d_in_beat.param   = d_in_param;
        w_d_in_beat.size    = d_in_size;
        w_d_in_beat.denied  = d_in_denied;
        w_d_in_beat.corrupt = d_in_corrupt;
        w_d_in_beat.data    = d_in_data;
    end

    // Comparison against a register only: the gate adds no input-to-output path.
    assign w_a_allow   = (r_inflight < 4'(MAX_INFLIGHT));
    assign a_out_valid = w_a_fifo_valid && w_a_allow;
    assign w_a_fire    = a_out_valid && a_out_ready;
    assign w_d_fire    = d_in_valid && d_in_ready;

    tl_ul_fifo2 #(
        .W     (c_a_w),
        .DEPTH (DEPTH)
    ) u_a_fifo (
        .clk         (clock),
        .rst         (reset),
        .i_in_valid  (a_in_valid),
        .o_in_ready  (a_in_ready),
        .i_in_data   ({a_in_source, w_a_in_beat}),
        .o_out_valid (w_a_fifo_valid),
        .i_out_ready (a_out_ready && w_a_allow),   // head is held while gated
        .o_out_data  (w_a_out_data)
    );

    tl_ul_fifo2 #(
        .W     (c_d_w),
        .DEPTH (DEPTH)
    ) u_d_fifo (
        .clk         (clock),
        .rst         (reset),
        .i_in_valid  (d_in_valid),
        .o_in_ready  (d_in_ready),
        .i_in_data   ({d_in_source, w_d_in_beat}),
        .o_out_valid (d_out_valid),
        .i_out_ready (d_out_ready),
        .o_out_data  (w_d_out_data)
    );

    assign {w_a_out_source, w_a_out_beat} = w_a_out_data;
    assign {w_d_out_source, w_d_out_beat} = w_d_out_data;

    assign a_out_opcode  = w_a_out_beat.opcode;
    assign a_out_param   = w_a_out_beat.param;
    assign a_out_size    = w_a_out_beat.size;
    assign a_out_source  = w_a_out_source;
    assign a_out_address = w_a_out_beat.address;
    assign a_out_mask    = w_a_out_beat.mask;
    assign a_out_corrupt = w_a_out_beat.corrupt;

    assign d_out_opcode  = w_d_out_beat.opcode;
    assign d_out_param   = w_d_out_beat.param;
    assign d_out_size    = w_d_out_beat.size;
    assign d_out_source  = w_d_out_source;
    assign d_out_denied  = w_d_out_beat.denied;
    assign d_out_corrupt = w_d_out_beat.corrupt;
    assign d_out_data    = w_d_out_beat.data;

    // Outstanding-request tracking. A D beat arriving with nothing
    // outstanding is still buffered; it only raises the error pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_inflight      <= 4'd0;
            r_err_underflow <= 1'b0;
        end else begin
            r_err_underflow <= 1'b0;
            case ({w_a_fire, w_d_fire})
                2'b10: r_inflight <= r_inflight + 4'd1;
                2'b01: begin
                    if (r_inflight == 4'd0) begin
                        r_err_underflow <= 1'b1;
                    end else begin
                        r_inflight <= r_inflight - 4'd1;
                    end
                end
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign inflight      = r_inflight;
    assign err_underflow = r_err_underflow;

endmodule : tl_ul_port_buffer
`default_nettype wire

// File: tb/tb_tl_ul_port_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tl_ul_port_buffer
// Description : Self-checking bench for tl_ul_port_buffer. Accepted input
//               beats are queued as expected output; a negedge monitor pops
//               and compares on every output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tl_ul_port_buffer;
    import tl_ul_port_buffer_pkg::*;

    localparam int SRC_W        = 2;
    localparam int MAX_INFLIGHT = 4;
    localparam int c_a_w = 9 + SRC_W + 32 + 8 + 1;
    localparam int c_d_w = 9 + SRC_W + 1 + 1 + 64;

    logic             clock = 1'b0;
    logic             reset;
    logic             a_in_valid, a_in_ready;
    logic [2:0]       a_in_opcode, a_in_param, a_in_size;
    logic [SRC_W-1:0] a_in_source;
    logic [31:0]      a_in_address;
    logic [7:0]       a_in_mask;
    logic             a_in_corrupt;
    logic             a_out_valid, a_out_ready;
    logic [2:0]       a_out_opcode, a_out_param, a_out_size;
    logic [SRC_W-1:0] a_out_source;
    logic [31:0]      a_out_address;
    logic [7:0]       a_out_mask;
    logic             a_out_corrupt;
    logic             d_in_valid, d_in_ready;
    logic [2:0]       d_in_opcode, d_in_param, d_in_size;
    logic [SRC_W-1:0] d_in_source;
    logic             d_in_denied, d_in_corrupt;
    logic [63:0]      d_in_data;
    logic             d_out_valid, d_out_ready;
    logic [2:0]       d_out_opcode, d_out_param, d_out_size;
    logic [SRC_W-1:0] d_out_source;
    logic             d_out_denied, d_out_corrupt;
    logic [63:0]      d_out_data;
    logic [3:0]       inflight;
    logic             err_underflow;

    int checks = 0;
    int errors = 0;

    logic [c_a_w-1:0] a_q[$];
    logic [c_d_w-1:0] d_q[$];

    tl_ul_port_buffer #(
        .SRC_W        (SRC_W),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .a_in_valid    (a_in_valid),
        .a_in_ready    (a_in_ready),
        .a_in_opcode   (a_in_opcode),
        .a_in_param    (a_in_param),
        .a_in_size     (a_in_size),
        .a_in_source   (a_in_source),
        .a_in_address  (a_in_address),
        .a_in_mask     (a_in_mask),
        .a_in_corrupt  (a_in_corrupt),
        .a_out_valid   (a_out_valid),
        .a_out_ready   (a_out_ready),
        .a_out_opcode  (a_out_opcode),
        .a_out_param   (a_out_param),
        .a_out_size    (a_out_size),
        .a_out_source  (a_out_source),
        .a_out_address (a_out_address),
        .a_out_mask    (a_out_mask),
        .a_out_corrupt (a_out_corrupt),
        .d_in_valid    (d_in_valid),
        .d_in_ready    (d_in_ready),
        .d_in_opcode   (d_in_opcode),
        .d_in_param    (d_in_param),
        .d_in_size     (d_in_size),
        .d_in_source   (d_in_source),
        .d_in_denied   (d_in_denied),
        .d_in_corrupt  (d_in_corrupt),
        .d_in_data     (d_in_data),
        .d_out_valid   (d_out_valid),
        .d_out_ready   (d_out_ready),
        .d_out_opcode  (d_out_opcode),
        .d_out_param   (d_out_param),
        .d_out_size    (d_out_size),
        .d_out_source  (d_out_source),
        .d_out_denied  (d_out_denied),
        .d_out_corrupt (d_out_corrupt),
        .d_out_data    (d_out_data),
        .inflight      (inflight),
        .err_underflow (err_underflow)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    // Scoreboard monitor: outputs are stable mid-cycle, so a handshake seen
    // at the negedge is the one that completes at the next posedge.
    always @(negedge clock) begin
        if (!reset && a_out_valid && a_out_ready) begin
            checks++;
            if (a_q.size() == 0) begin
                errors++;
                $display("FAIL a_order: unexpected A beat %h, required none", {a_out_opcode, a_out_param, a_out_size, a_out_source, a_out_address, a_out_mask, a_out_corrupt});
            end else if ({a_out_opcode, a_out_param, a_out_size, a_out_source, a_out_address, a_out_mask, a_out_corrupt} !== a_q[0]) begin
                errors++;
                $display("FAIL a_beat: got %h, required %h", {a_out_opcode, a_out_param, a_out_size, a_out_source, a_out_address, a_out_mask, a_out_corrupt}, a_q[0]);
                void'(a_q.pop_front());
            end else begin
                void'(a_q.pop_front());
            end
        end
        if (!reset && d_out_valid && d_out_ready) begin
            checks++;
            if (d_q.size() == 0) begin
                errors++;
                $display("FAIL d_order: unexpected D beat %h, required none", {d_out_opcode, d_out_param, d_out_size, d_out_source, d_out_denied, d_out_corrupt, d_out_data});
            end else if ({d_out_opcode, d_out_param, d_out_size, d_out_source, d_out_denied, d_out_corrupt, d_out_data} !== d_q[0]) begin
                errors++;
                $display("FAIL d_beat: got %h, required %h", {d_out_opcode, d_out_param, d_out_size, d_out_source, d_out_denied, d_out_corrupt, d_out_data}, d_q[0]);
                void'(d_q.pop_front());
            end else begin
                void'(d_q.pop_front());
            end
        end
    end

    // ---- stimulus drivers (called at posedge+1, return at posedge+1) ----
    task automatic send_a(input logic [2:0] opc, input logic [31:0] addr,
                          input logic [7:0] mask, input logic [SRC_W-1:0] src);
        bit done = 0;
        a_in_opcode  = opc;
        a_in_param   = addr[2:0];
        a_in_size    = 3'd3;
        a_in_source  = src;
        a_in_address = addr;
        a_in_mask    = mask;
        a_in_corrupt = addr[3];
        a_in_valid   = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clock);
            if (a_in_ready) begin
                a_q.push_back({opc, addr[2:0], 3'd3, src, addr, mask, addr[3]});
                done = 1;
            end
            @(posedge clock);
            #1;
        end
        a_in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL a_accept_timeout: a_in_ready stayed 0, required 1");
        end
    endtask

    task automatic send_d(input logic [2:0] opc, input logic [SRC_W-1:0] src,
                          input logic [63:0] data);
        bit done = 0;
        d_in_opcode  = opc;
        d_in_param   = 3'd0;
        d_in_size    = 3'd3;
        d_in_source  = src;
        d_in_denied  = data[63];
        d_in_corrupt = data[0];
        d_in_data    = data;
        d_in_valid   = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clock);
            if (d_in_ready) begin
                d_q.push_back({opc, 3'd0, 3'd3, src, data[63], data[0], data});
                done = 1;
            end
            @(posedge clock);
            #1;
        end
        d_in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL d_accept_timeout: d_in_ready stayed 0, required 1");
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && (a_q.size() != 0 || d_q.size() != 0); i++) begin
            @(posedge clock);
            #1;
        end
        checks++;
        if (a_q.size() != 0 || d_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d A and %0d D beats still expected, required 0", a_q.size(), d_q.size());
        end
    endtask

    task automatic check_inflight(input string name, input logic [3:0] exp);
        checks++;
        if (inflight !== exp) begin
            errors++;
            $display("FAIL %s: inflight=%0d, required %0d", name, inflight, exp);
        end
    endtask

    task automatic retire(input int n);
        for (int i = 0; i < n; i++) begin
            send_d(c_d_access_ack, SRC_W'(i), {$urandom, $urandom});
        end
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({a_out_valid, d_out_valid, a_in_ready, d_in_ready, err_underflow} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: {aov,dov,air,dir,err}=%b, required 00000", {a_out_valid, d_out_valid, a_in_ready, d_in_ready, err_underflow});
        end
        check_inflight("reset_inflight", 4'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if ({a_in_ready, d_in_ready} !== 2'b11) begin
            errors++;
            $display("FAIL reset_release_ready: {air,dir}=%b, required 11", {a_in_ready, d_in_ready});
        end
    endtask

    task automatic test_single_get();
        a_out_ready = 1'b0;
        send_a(c_a_get, 32'h8000_0000, 8'hFF, 2'd1);
        checks++;
        if (a_out_valid !== 1'b1 || a_out_opcode !== 3'd4 || a_out_address !== 32'h8000_0000 ||
            a_out_mask !== 8'hFF || a_out_source !== 2'd1) begin
            errors++;
            $display("FAIL get_latency: valid=%b opc=%0d addr=%h mask=%h src=%0d, required 1 4 80000000 ff 1",
                     a_out_valid, a_out_opcode, a_out_address, a_out_mask, a_out_source);
        end
        a_out_ready = 1'b1;
        @(posedge clock);
        #1;
        check_inflight("get_inflight", 4'd1);
        send_d(c_d_access_ack_data, 2'd1, 64'h0123_4567_89AB_CDEF);
        check_inflight("get_retired", 4'd0);
        wait_drain();
    endtask

    task automatic test_backpressure();
        a_out_ready = 1'b0;
        send_a(c_a_put_full_data, 32'h0000_1000, 8'h0F, 2'd0);
        send_a(c_a_put_full_data, 32'h0000_2008, 8'hF0, 2'd1);
        a_in_address = 32'h0000_300C;
        a_in_valid   = 1'b1;
        @(negedge clock);
        checks++;
        if (a_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full_ready: a_in_ready=%b, required 0", a_in_ready);
        end
        @(posedge clock);
        #1;
        a_out_ready = 1'b1;
        send_a(c_a_put_partial_data, 32'h0000_300C, 8'h3C, 2'd2);
        wait_drain();
        check_inflight("bp_inflight", 4'd3);
        retire(3);
        check_inflight("bp_retired", 4'd0);
        wait_drain();
    endtask

    task automatic test_max_inflight();
        a_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_a(c_a_put_full_data, $urandom & 32'hFFFF_FFF8, 8'(i + 1), SRC_W'(i));
        end
        repeat (2) @(posedge clock);
        #1;
        check_inflight("max_inflight", 4'(MAX_INFLIGHT));
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL max_gated: a_out_valid=%b, required 0", a_out_valid);
        end
        send_d(c_d_access_ack, 2'd0, 64'h0);
        checks++;
        if (a_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL max_release: a_out_valid=%b, required 1", a_out_valid);
        end
        @(posedge clock);
        #1;
        check_inflight("max_refill", 4'(MAX_INFLIGHT));
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL max_empty: a_out_valid=%b, required 0", a_out_valid);
        end
        retire(MAX_INFLIGHT);
        check_inflight("max_retired", 4'd0);
        wait_drain();
    endtask

    task automatic test_simultaneous();
        a_out_ready = 1'b1;
        send_a(c_a_get, 32'h1000_0000, 8'hFF, 2'd0);
        send_a(c_a_get, 32'h1000_0008, 8'hFF, 2'd1);
        repeat (2) @(posedge clock);
        #1;
        check_inflight("sim_pre", 4'd2);
        a_out_ready = 1'b0;
        send_a(c_a_get, 32'h1000_0010, 8'hFF, 2'd2);
        a_out_ready  = 1'b1;
        d_in_opcode  = c_d_access_ack_data;
        d_in_param   = 3'd0;
        d_in_size    = 3'd3;
        d_in_source  = 2'd0;
        d_in_denied  = 1'b0;
        d_in_corrupt = 1'b0;
        d_in_data    = 64'hDEAD_BEEF_CAFE_F00D;
        d_in_valid   = 1'b1;
        @(negedge clock);
        checks++;
        if ({a_out_valid, d_in_ready} !== 2'b11) begin
            errors++;
            $display("FAIL sim_both_fire: {aov,dir}=%b, required 11", {a_out_valid, d_in_ready});
        end
        d_q.push_back({c_d_access_ack_data, 3'd0, 3'd3, 2'd0, 1'b0, 1'b0, 64'hDEAD_BEEF_CAFE_F00D});
        @(posedge clock);
        #1;
        d_in_valid = 1'b0;
        check_inflight("sim_hold", 4'd2);
        retire(2);
        check_inflight("sim_retired", 4'd0);
        wait_drain();
    endtask

    task automatic test_underflow();
        d_out_ready = 1'b1;
        send_d(c_d_access_ack, 2'd3, 64'h5555_AAAA_5555_AAAA);
        checks++;
        if ({err_underflow, d_out_valid} !== 2'b11) begin
            errors++;
            $display("FAIL uf_pulse: {err,dov}=%b, required 11", {err_underflow, d_out_valid});
        end
        check_inflight("uf_inflight", 4'd0);
        @(posedge clock);
        #1;
        checks++;
        if (err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL uf_one_cycle: err_underflow=%b, required 0", err_underflow);
        end
        wait_drain();
    endtask

    task automatic test_reset_mid();
        a_out_ready = 1'b0;
        d_out_ready = 1'b0;
        send_a(c_a_put_full_data, 32'h2000_0000, 8'hFF, 2'd0);
        send_a(c_a_put_full_data, 32'h2000_0008, 8'hFF, 2'd1);
        send_d(c_d_access_ack, 2'd0, 64'h1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if ({a_out_valid, d_out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_valid: {aov,dov}=%b, required 00", {a_out_valid, d_out_valid});
        end
        check_inflight("mid_reset_inflight", 4'd0);
        a_q.delete();
        d_q.delete();
        reset = 1'b0;
        @(posedge clock);
        #1;
        a_out_ready = 1'b1;
        d_out_ready = 1'b1;
        send_a(c_a_get, 32'h3000_0040, 8'hFF, 2'd3);
        checks++;
        if (a_out_valid !== 1'b1 || a_out_address !== 32'h3000_0040) begin
            errors++;
            $display("FAIL mid_post_latency: valid=%b addr=%h, required 1 30000040", a_out_valid, a_out_address);
        end
        wait_drain();
        retire(1);
        check_inflight("mid_retired", 4'd0);
        wait_drain();
    endtask

    initial begin
        reset        = 1'b1;
        a_in_valid   = 1'b0;
        a_in_opcode  = '0;
        a_in_param   = '0;
        a_in_size    = '0;
        a_in_source  = '0;
        a_in_address = '0;
        a_in_mask    = '0;
        a_in_corrupt = 1'b0;
        a_out_ready  = 1'b0;
        d_in_valid   = 1'b0;
        d_in_opcode  = '0;
        d_in_param   = '0;
        d_in_size    = '0;
        d_in_source  = '0;
        d_in_denied  = 1'b0;
        d_in_corrupt = 1'b0;
        d_in_data    = '0;
        d_out_ready  = 1'b1;
        @(posedge clock);
        #1;
        test_reset();
        test_single_get();
        test_backpressure();
        test_max_inflight();
        test_simultaneous();
        test_underflow();
        test_reset_mid();
        repeat (2) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_tl_ul_port_buffer
`default_nettype wire
